vga_timing_gen: RTL

Parametrised VGA raster timing generator replacing the fixed 640x480 counter pair. Advances one pixel per `pixel_tick` strobe, produces programmable-polarity hsync/vsync, display-enable, pixel coordinates and line/frame/vblank strobes. Optionally maps the raster onto the 64x32 CHIP-8 framebuffer grid. Sits between the timer block (pixel tick source) and the pixel/colour stage feeding `vga_r/g/b`.

---
 rtl/vga_timing_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator; advances one pixel per pixel_tick_i strobe.
// Define VGA_TIMING_CELL_EN to also map the raster onto the 64x32 CHIP-8 cell grid.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE      = 640,
  parameter int unsigned H_FP          = 16,
  parameter int unsigned H_SYNC        = 96,
  parameter int unsigned H_BP          = 48,
  parameter int unsigned V_ACTIVE      = 480,
  parameter int unsigned V_FP          = 10,
  parameter int unsigned V_SYNC        = 2,
  parameter int unsigned V_BP          = 33,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter bit          VSYNC_POL     = 1'b0,
  parameter int unsigned CNT_W         = 11,
  parameter int unsigned CELL_SCALE    = 10,
  parameter int unsigned CELL_Y_OFFSET = 80
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pixel_tick_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             de_o,
  output logic             vga_hsync_o,
  output logic             vga_vsync_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic             vblank_start_o,
  output logic [5:0]       cell_x_o,
  output logic [4:0]       cell_y_o,
  output logic             cell_valid_o
);

  localparam int unsigned HTotal     = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal     = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
  localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
  localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
  localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
  localparam logic [CNT_W-1:0] HLast = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast = CNT_W'(VTotal - 1);

  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic vblank_start_q, vblank_start_d;

  // All decodes are taken from the next position so they land together with x/y.
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (x_q == HLast) begin
      x_d = '0;
      y_d = (y_q == VLast) ? '0 : y_q + 1'b1;
    end
    de_d    = (32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE);
    hsync_d = ((32'(x_d) >= HSyncStart) && (32'(x_d) < HSyncEnd)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((32'(y_d) >= VSyncStart) && (32'(y_d) < VSyncEnd)) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d   = (x_d == '0);
    frame_start_d  = line_start_d && (y_d == '0);
    vblank_start_d = line_start_d && (32'(y_d) == V_ACTIVE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q            <= HLast;
      y_q            <= VLast;
      de_q           <= 1'b0;
      hsync_q        <= ~HSYNC_POL;
      vsync_q        <= ~VSYNC_POL;
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
    end else begin
      line_start_q   <= 1'b0;
      frame_start_q  <= 1'b0;
      vblank_start_q <= 1'b0;
      if (pixel_tick_i) begin
        x_q            <= x_d;
        y_q            <= y_d;
        de_q           <= de_d;
        hsync_q        <= hsync_d;
        vsync_q        <= vsync_d;
        line_start_q   <= line_start_d;
        frame_start_q  <= frame_start_d;
        vblank_start_q <= vblank_start_d;
      end
    end
  end

  assign x_o            = x_q;
  assign y_o            = y_q;
  assign de_o           = de_q;
  assign vga_hsync_o    = hsync_q;
  assign vga_vsync_o    = vsync_q;
  assign line_start_o   = line_start_q;
  assign frame_start_o  = frame_start_q;
  assign vblank_start_o = vblank_start_q;

`ifdef VGA_TIMING_CELL_EN
  localparam int unsigned CellXEnd = 64 * CELL_SCALE;
  localparam int unsigned CellYEnd = CELL_Y_OFFSET + 32 * CELL_SCALE;
  localparam logic [CNT_W-1:0] SubLast = CNT_W'(CELL_SCALE - 1);

  logic [CNT_W-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
  logic [5:0] hcell_q, hcell_d, cell_x_q, cell_x_d;
  logic [4:0] vcell_q, vcell_d, cell_y_q, cell_y_d;
  logic cell_valid_q, cell_valid_d;

  // Sub-counters divide by CELL_SCALE; cell indices may wrap outside the grid, where they are masked.
  always_comb begin
    hsub_d  = hsub_q + 1'b1;
    hcell_d = hcell_q;
    if (x_d == '0) begin
      hsub_d  = '0;
      hcell_d = '0;
    end else if (hsub_q == SubLast) begin
      hsub_d  = '0;
      hcell_d = hcell_q + 1'b1;
    end
    vsub_d  = vsub_q;
    vcell_d = vcell_q;
    if (x_d == '0) begin
      if (32'(y_d) == CELL_Y_OFFSET) begin
        vsub_d  = '0;
        vcell_d = '0;
      end else if (vsub_q == SubLast) begin
        vsub_d  = '0;
        vcell_d = vcell_q + 1'b1;
      end else begin
        vsub_d = vsub_q + 1'b1;
      end
    end
    cell_valid_d = de_d && (32'(x_d) < CellXEnd) && (32'(y_d) >= CELL_Y_OFFSET) &&
                   (32'(y_d) < CellYEnd);
    cell_x_d = cell_valid_d ? hcell_d : '0;
    cell_y_d = cell_valid_d ? vcell_d : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hsub_q       <= '0;
      vsub_q       <= '0;
      hcell_q      <= '0;
      vcell_q      <= '0;
      cell_x_q     <= '0;
      cell_y_q     <= '0;
      cell_valid_q <= 1'b0;
    end else if (pixel_tick_i) begin
      hsub_q       <= hsub_d;
      vsub_q       <= vsub_d;
      hcell_q      <= hcell_d;
      vcell_q      <= vcell_d;
      cell_x_q     <= cell_x_d;
      cell_y_q     <= cell_y_d;
      cell_valid_q <= cell_valid_d;
    end
  end

  assign cell_x_o     = cell_x_q;
  assign cell_y_o     = cell_y_q;
  assign cell_valid_o = cell_valid_q;
`else
  assign cell_x_o     = '0;
  assign cell_y_o     = '0;
  assign cell_valid_o = 1'b0;
`endif

endmodule
